// File: rtl/ext_pipe.sv
// Operand-extension unit: zero/sign extension, LUI placement, branch-offset scaling
// and byte/halfword load extraction, behind a valid/ready handshake with one skid entry.
module ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 5,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_word,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    typedef enum logic [2:0] {
        MODE_ZEXT = 3'd0,
        MODE_SEXT = 3'd1,
        MODE_LUI  = 3'd2,
        MODE_BOFF = 3'd3,
        MODE_LB   = 3'd4,
        MODE_LBU  = 3'd5,
        MODE_LH   = 3'd6,
        MODE_LHU  = 3'd7
    } mode_e;

    logic [DATA_W-1:0] zext_w;
    logic [DATA_W-1:0] sext_w;
    logic [DATA_W-1:0] lui_w;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [OFF_W+2:0]  byte_idx;
    logic [OFF_W+2:0]  half_idx;
    logic [DATA_W-1:0] res_data;
    logic              res_err;

    always_comb begin
        zext_w              = '0;
        zext_w[IMM_W-1:0]   = in_imm;
        sext_w              = {DATA_W{in_imm[IMM_W-1]}};
        sext_w[IMM_W-1:0]   = in_imm;
        lui_w               = '0;
        lui_w[DATA_W-1 -: IMM_W] = in_imm;
        byte_idx            = {in_off, 3'b000};
        // Misaligned halfwords fall back to the aligned lane below them.
        half_idx            = {in_off[OFF_W-1:1], 4'b0000};
        byte_sel            = in_word[byte_idx +: 8];
        half_sel            = in_word[half_idx +: 16];
        res_data            = '0;
        res_err             = 1'b0;
        case (mode_e'(in_mode))
            MODE_ZEXT: res_data = zext_w;
            MODE_SEXT: res_data = sext_w;
            MODE_LUI:  res_data = lui_w;
            MODE_BOFF: res_data = sext_w << 2;
            MODE_LB: begin
                res_data       = {DATA_W{byte_sel[7]}};
                res_data[7:0]  = byte_sel;
            end
            MODE_LBU: res_data[7:0] = byte_sel;
            MODE_LH: begin
                res_data       = {DATA_W{half_sel[15]}};
                res_data[15:0] = half_sel;
                res_err        = in_off[0];
            end
            MODE_LHU: begin
                res_data[15:0] = half_sel;
                res_err        = in_off[0];
            end
            default: res_data = '0;
        endcase
    end

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
    logic              main_err_q,   main_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;
    logic              skid_err_q,   skid_err_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (skid_valid_q) begin
            // in_ready is low here, so the only possible move is skid -> main.
            if (out_fire) begin
                main_data_d  = skid_data_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_ready) begin
                main_valid_d = 1'b1;
                main_data_d  = res_data;
                main_tag_d   = in_tag;
                main_err_d   = res_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = res_data;
                skid_tag_d   = in_tag;
                skid_err_d   = res_err;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: 32-bit instance driven through a queue/monitor pair,
// plus a 64-bit instance for the wide byte-lane case.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_imm;
    logic [31:0] in_word;
    logic [1:0]  in_off;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    logic        v64, r64, ov64, or64, oe64;
    logic [2:0]  mode64;
    logic [15:0] imm64;
    logic [63:0] word64, od64;
    logic [2:0]  off64;
    logic [4:0]  tag64, ot64;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm),
        .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    ext_pipe #(.DATA_W(64), .IMM_W(16), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v64), .in_ready(r64), .in_mode(mode64), .in_imm(imm64),
        .in_word(word64), .in_off(off64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(or64), .out_data(od64),
        .out_tag(ot64), .out_err(oe64)
    );

    // Monitor: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_result actual data=%h tag=%0d, required none", out_data, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.d || out_tag !== e.t || out_err !== e.e) begin
                    fails = fails + 1;
                    $display("FAIL scoreboard actual data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                             out_data, out_tag, out_err, e.d, e.t, e.e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the input transfer.
    task automatic send(input logic [2:0] mode, input logic [15:0] imm, input logic [31:0] word,
                        input logic [1:0] off, input logic [4:0] tag,
                        input logic [31:0] ed, input logic ee);
        int n = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_imm   = imm;
        in_word  = word;
        in_off   = off;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL send_timeout actual in_ready=0, required 1 (tag %0d)", tag);
        end else begin
            exp_q.push_back('{d: ed, t: tag, e: ee});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain_timeout actual pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = 3'd0; in_imm = '0; in_word = '0; in_off = '0; in_tag = '0;
        out_ready = 1'b1;
        v64 = 1'b0; mode64 = 3'd0; imm64 = '0; word64 = '0; off64 = '0; tag64 = '0; or64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_data",  {32'd0, out_data},  64'd0);
        check("rst_out_tag",   {59'd0, out_tag},   64'd0);
        check("rst_out_err",   {63'd0, out_err},   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Immediate modes; first result checked directly for 1-cycle latency.
        send(3'd0, 16'h8001, 32'hDEADBEEF, 2'd3, 5'd1, 32'h0000_8001, 1'b0);
        check("zext_latency_valid", {63'd0, out_valid}, 64'd1);
        check("zext_latency_data",  {32'd0, out_data},  64'h0000_8001);
        send(3'd1, 16'h8001, 32'h0,        2'd0, 5'd2, 32'hFFFF_8001, 1'b0);
        send(3'd2, 16'h1234, 32'h0,        2'd0, 5'd3, 32'h1234_0000, 1'b0);
        send(3'd3, 16'hFFFF, 32'h0,        2'd0, 5'd4, 32'hFFFF_FFFC, 1'b0);
        send(3'd3, 16'h0101, 32'h0,        2'd0, 5'd5, 32'h0000_0404, 1'b0);

        // Loads from 0x80FF7F01 (lanes: 01, 7F, FF, 80).
        send(3'd4, 16'hFFFF, 32'h80FF_7F01, 2'd3, 5'd6,  32'hFFFF_FF80, 1'b0);
        send(3'd5, 16'hFFFF, 32'h80FF_7F01, 2'd3, 5'd7,  32'h0000_0080, 1'b0);
        send(3'd4, 16'h0,    32'h80FF_7F01, 2'd1, 5'd8,  32'h0000_007F, 1'b0);
        send(3'd6, 16'h0,    32'h80FF_7F01, 2'd2, 5'd9,  32'hFFFF_80FF, 1'b0);
        send(3'd7, 16'h0,    32'h80FF_7F01, 2'd0, 5'd10, 32'h0000_7F01, 1'b0);
        send(3'd6, 16'h0,    32'h80FF_7F01, 2'd1, 5'd11, 32'h0000_7F01, 1'b1);
        send(3'd7, 16'h0,    32'h80FF_7F01, 2'd3, 5'd12, 32'h0000_80FF, 1'b1);
        drain();

        // Backpressure: two accepts fill main and skid, then in_ready drops.
        out_ready = 1'b0;
        send(3'd1, 16'h8001, 32'h0, 2'd0, 5'd1, 32'hFFFF_8001, 1'b0);
        check("bp_in_ready_after1", {63'd0, in_ready}, 64'd1);
        send(3'd1, 16'h8002, 32'h0, 2'd0, 5'd2, 32'hFFFF_8002, 1'b0);
        check("bp_in_ready_after2", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_data",  {32'd0, out_data},  64'hFFFF_8001);
            check("bp_hold_tag",   {59'd0, out_tag},   64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd1, 16'h0003, 32'h0, 2'd0, 5'd3, 32'h0000_0003, 1'b0);
        send(3'd1, 16'hF004, 32'h0, 2'd0, 5'd4, 32'hFFFF_F004, 1'b0);
        drain();

        // Async reset with both entries occupied.
        out_ready = 1'b0;
        send(3'd0, 16'h00AA, 32'h0, 2'd0, 5'd20, 32'h0000_00AA, 1'b0);
        send(3'd0, 16'h00BB, 32'h0, 2'd0, 5'd21, 32'h0000_00BB, 1'b0);
        check("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("async_rst_out_data",  {32'd0, out_data},  64'd0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(3'd1, 16'h7FFF, 32'h0, 2'd0, 5'd7, 32'h0000_7FFF, 1'b0);
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_tag",   {59'd0, out_tag},   64'd7);
        drain();
        for (int i = 0; i < 3; i++) begin
            check("post_rst_idle", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
            #1;
        end

        // 64-bit instance: top byte lane.
        v64 = 1'b1; mode64 = 3'd4; word64 = 64'h8000_0000_0000_0000; off64 = 3'd7; tag64 = 5'd9;
        check("w64_in_ready", {63'd0, r64}, 64'd1);
        @(posedge clk);
        #1;
        v64 = 1'b0;
        check("w64_lb_valid", {63'd0, ov64}, 64'd1);
        check("w64_lb_data",  od64, 64'hFFFF_FFFF_FFFF_FF80);
        check("w64_lb_tag",   {59'd0, ot64}, 64'd9);
        v64 = 1'b1; mode64 = 3'd7; word64 = 64'h1234_5678_9ABC_DEF0; off64 = 3'd5; tag64 = 5'd10;
        @(posedge clk);
        #1;
        v64 = 1'b0;
        check("w64_lhu_data", od64, 64'h0000_0000_0000_5678);
        check("w64_lhu_err",  {63'd0, oe64}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined operand-extension unit for the MIPS datapath. It generalises the 16→32 sign extender into one block with eight modes: zero/sign extension, LUI placement, branch-offset scaling, and byte/halfword load-data extraction with sign or zero fill. It sits between decode/memory and execute/writeback behind a valid/ready handshake, so it tolerates downstream stalls without dropping operands. It has one output register stage and one skid register.

## Interface
Parameters:
- DATA_W, default 32: output and load-word width; legal values are 32 and 64.
- IMM_W, default 16: immediate width; must satisfy 8 ≤ IMM_W ≤ DATA_W.
- TAG_W, default 5: sideband tag carried alongside the operand (for example, the destination register).
- OFF_W: derived, equal to log2(DATA_W/8); not user-set.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_mode  in  3  operation select (encodings under Operation).
- in_imm  in  IMM_W  immediate field.
- in_word  in  DATA_W  loaded memory word.
- in_off  in  OFF_W  byte address offset within in_word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag that travelled with the result.
- out_err  out  1  misaligned halfword access flag.

## Operation
Mode encodings:
- 0 ZEXT: DATA_W-IMM_W zeros, then in_imm.
- 1 SEXT: DATA_W-IMM_W copies of in_imm[IMM_W-1], then in_imm.
- 2 LUI: in_imm in the top bits, low DATA_W-IMM_W bits zero.
- 3 BOFF: SEXT result shifted left by 2, truncated to DATA_W bits.
- 4 LB: byte lane in_off of in_word (bits 8·off+7 .. 8·off), sign-extended.
- 5 LBU: same byte lane, zero-extended.
- 6 LH: halfword lane in_off[OFF_W-1:1], sign-extended. If in_off[0]=1, out_err=1 and data is computed with in_off[0] treated as 0.
- 7 LHU: as LH but zero-extended; same error rule.

Common rules:
- out_err is 0 for modes 0–5.
- in_imm is ignored in modes 4–7; in_word and in_off are ignored in modes 0–3.

Buffering:
- The main register drives out_*. The skid register holds one extra entry.
- Input transfer happens when in_valid && in_ready.
- Output transfer happens when out_valid && out_ready.
- in_ready = !skid_valid. It is driven directly from the register, with no combinational path from out_ready.
- Main empty, or main draining this cycle: the computed result loads into main.
- Main full and stalled: the computed result loads into skid.
- Main draining while skid is full: skid moves to main; in_ready was 0, so there is no input this cycle.
- Ordering is strictly FIFO. Results never drop and never duplicate.

## Timing
- Latency: the result is visible on out_* the cycle after the input transfer (1 cycle).
- Throughput: 1 result per cycle while out_ready=1.
- Stall hold: while out_valid=1 and out_ready=0, out_data, out_tag and out_err stay stable.
- Backpressure delay: in_ready falls one cycle after the stalled capture into skid. It rises the cycle after skid drains into main.
- Reset values, applied immediately on rst_n=0: out_valid=0, skid_valid=0, in_ready=1, out_data=0, out_tag=0, out_err=0.
- Reset mid-operation discards both entries. The first cycle after rst_n rises accepts new input.
- Simultaneous in-transfer and out-transfer with skid empty: the new result replaces main and out_valid stays 1.

## Test plan
- Reset then ZEXT/SEXT, DATA_W=32, IMM_W=16: in_imm=0x8001 with mode 0 → 0x00008001; with mode 1 → 0xFFFF8001, appearing 1 cycle after transfer.
- LUI/BOFF: in_imm=0x1234 with mode 2 → 0x12340000. in_imm=0xFFFF with mode 3 → 0xFFFFFFFC.
- Loads, in_word=0x80FF7F01:
  - LB with off=3 → 0xFFFFFF80.
  - LBU with off=3 → 0x00000080.
  - LH with off=2 → 0xFFFF80FF.
  - LHU with off=0 → 0x00007F01.
  - LH with off=1 → 0x00007F01 and out_err=1.
- Backpressure: stream 4 tagged SEXT operands (tags 1..4) with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepted operands.
  - Outputs hold stable during the stall.
  - Releasing out_ready delivers tags 1,2,3,4 in order with no loss.
- Async reset: assert rst_n=0 mid-cycle while both entries are full. out_valid must be 0 and in_ready must be 1 immediately, with no further results after release.
- DATA_W=64, OFF_W=3: LB with off=7 on in_word=0x80000000_00000000 → 0xFFFFFFFF_FFFFFF80.
